// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one full adder time-shared over WIDTH cycles,
// operands consumed LSB first with the carry held in a flip-flop between bits.
`timescale 1ns/1ps

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

// Handshake: start/op_sub/a/b are sampled on a rising edge only while busy=0
// (IDLE or DONE); busy covers the WIDTH bit steps, done pulses for one cycle
// and sum/c_out/ovf are valid from that cycle until the next operation completes.
module serial_add_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic [1:0]       state_o
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;
   logic             fa_s, fa_c;
   logic             accept;
   logic             last_bit;

   full_adder u_fa (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .c_i (cy_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   assign accept   = start && (state_q != S_RUN);

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      busy    = 1'b0;
      done    = 1'b0;

      case (state_q)
         S_IDLE: ;
         S_RUN: begin
            busy   = 1'b1;
            acc_d  = {fa_s, acc_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            cy_d   = fa_c;
            if (last_bit) begin
               // cy_q is the carry into the MSB, so it disagrees with the carry out on overflow
               sum_d   = {fa_s, acc_q[WIDTH-1:1]};
               c_out_d = fa_c;
               ovf_d   = fa_c ^ cy_q;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Subtraction is a + ~b + 1, the +1 entering as the initial carry
      if (accept) begin
         a_sh_d  = a;
         b_sh_d  = op_sub ? ~b : b;
         cy_d    = op_sub;
         cnt_d   = '0;
         acc_d   = '0;
         state_d = S_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum     = sum_q;
   assign c_out   = c_out_q;
   assign ovf     = ovf_q;
   assign state_o = state_q;
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: WIDTH=8 and WIDTH=16 instances checked every cycle
// against an arithmetic reference model, plus directed literal vectors.
`timescale 1ns/1ps

module tb_serial_add_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmp_en;
   logic        st[2];
   logic        sb[2];
   logic [15:0] av[2];
   logic [15:0] bv[2];

   logic        b8, d8, c8, o8, b16, d16, c16, o16;
   logic [7:0]  sum8;
   logic [15:0] sum16;
   logic [1:0]  dbg8, dbg16;
   logic        busy_w[2], done_w[2], c_w[2], o_w[2];
   logic [15:0] sum_w[2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   serial_add_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .op_sub(sb[0]),
      .a(av[0][7:0]), .b(bv[0][7:0]), .busy(b8), .done(d8),
      .sum(sum8), .c_out(c8), .ovf(o8), .state_o(dbg8)
   );

   serial_add_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .op_sub(sb[1]),
      .a(av[1]), .b(bv[1]), .busy(b16), .done(d16),
      .sum(sum16), .c_out(c16), .ovf(o16), .state_o(dbg16)
   );

   always_comb begin
      busy_w[0] = b8;   busy_w[1] = b16;
      done_w[0] = d8;   done_w[1] = d16;
      c_w[0]    = c8;   c_w[1]    = c16;
      o_w[0]    = o8;   o_w[1]    = o16;
      sum_w[0]  = {8'h00, sum8};
      sum_w[1]  = sum16;
   end

   function automatic int wof(input int k);
      return (k == 0) ? 8 : 16;
   endfunction

   // Reference result {c_out, ovf, sum[15:0]} from plain integer arithmetic
   function automatic logic [17:0] ref_op(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic sub);
      int unsigned mask, an, bn, r;
      logic c, o, sa, sy, sr;
      mask = (32'd1 << w) - 32'd1;
      an = {16'h0, x} & mask;
      bn = {16'h0, y} & mask;
      if (sub) begin
         r = (an - bn) & mask;
         c = (an >= bn);
      end else begin
         r = an + bn;
         c = ((r >> w) & 32'd1) != 0;
         r = r & mask;
      end
      sa = ((an >> (w - 1)) & 32'd1) != 0;
      sy = ((bn >> (w - 1)) & 32'd1) != 0;
      sr = ((r  >> (w - 1)) & 32'd1) != 0;
      o  = sub ? ((sa != sy) && (sr != sa)) : ((sa == sy) && (sr != sa));
      return {c, o, r[15:0]};
   endfunction

   // Timing model: accept when not busy, result appears WIDTH edges later
   logic        m_busy[2], m_done[2], m_c[2], m_o[2], p_sub[2];
   logic [15:0] m_sum[2], p_a[2], p_b[2];
   int          m_left[2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_c[k] <= 1'b0; m_o[k] <= 1'b0;
            m_sum[k]  <= '0;   m_left[k] <= 0;
         end else if (m_busy[k]) begin
            m_left[k] <= m_left[k] - 1;
            if (m_left[k] == 1) begin
               m_busy[k] <= 1'b0;
               m_done[k] <= 1'b1;
               {m_c[k], m_o[k], m_sum[k]} <= ref_op(wof(k), p_a[k], p_b[k], p_sub[k]);
            end
         end else begin
            m_done[k] <= 1'b0;
            if (st[k]) begin
               m_busy[k] <= 1'b1;
               m_left[k] <= wof(k);
               p_a[k]    <= av[k];
               p_b[k]    <= bv[k];
               p_sub[k]  <= sb[k];
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < 2; k++)
            check($sformatf("cycle w%0d {busy,done,c,ovf,sum}", wof(k)),
                  {12'h0, busy_w[k], done_w[k], c_w[k], o_w[k], sum_w[k]},
                  {12'h0, m_busy[k], m_done[k], m_c[k], m_o[k], m_sum[k]});
      end
   end

   // Called at a negedge; returns at the negedge right after the accepting edge
   task automatic launch(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic ts);
      st[k] = 1'b1; av[k] = ta; bv[k] = tb_v; sb[k] = ts;
      @(negedge clk);
      st[k] = 1'b0;
      av[k] = 16'($urandom); bv[k] = 16'($urandom); sb[k] = 1'($urandom_range(0, 1));
   endtask

   // cyc counts edges since acceptance; done is due at cyc == WIDTH
   task automatic finish_op(input int k, input int c0, input int bc0, input bit lit,
                            input logic [15:0] es, input logic ec, input logic eo,
                            input string name);
      int cyc, bc;
      cyc = c0; bc = bc0;
      while (!done_w[k] && cyc < wof(k) + 4) begin
         if (busy_w[k]) bc++;
         @(negedge clk);
         cyc++;
      end
      check({name, " latency"}, cyc, wof(k));
      check({name, " busy cycles"}, bc, wof(k));
      if (lit) begin
         check({name, " dut result"}, {c_w[k], o_w[k], sum_w[k]}, {ec, eo, es});
         check({name, " model result"}, {m_c[k], m_o[k], m_sum[k]}, {ec, eo, es});
      end
   endtask

   task automatic do_op(input int k, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic [15:0] es, input logic ec,
                        input logic eo, input string name);
      launch(k, ta, tb_v, ts);
      finish_op(k, 0, 0, 1'b1, es, ec, eo, name);
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         st[k] = 1'b0; sb[k] = 1'b0; av[k] = '0; bv[k] = '0;
      end
      cmp_en = 1'b0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset outputs", {b8, d8, c8, o8, sum8}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(0, 16'h3C, 16'h0F, 1'b0, 16'h4B, 1'b0, 1'b0, "add 3C+0F");
      do_op(0, 16'h7F, 16'h01, 1'b0, 16'h80, 1'b0, 1'b1, "add 7F+01");
      do_op(0, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1, 1'b0, "add FF+01");
      do_op(0, 16'h05, 16'h07, 1'b1, 16'hFE, 1'b0, 1'b0, "sub 05-07");
      do_op(0, 16'h80, 16'h01, 1'b1, 16'h7F, 1'b1, 1'b1, "sub 80-01");
      do_op(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "add16 7FFF+1");
      do_op(1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub16 0-1");

      // Start pulse mid-run is ignored; operand changes after acceptance are harmless
      launch(0, 16'h10, 16'h20, 1'b0);
      @(negedge clk);
      @(negedge clk);
      st[0] = 1'b1; av[0] = 16'hAA;
      @(negedge clk);
      st[0] = 1'b0; bv[0] = 16'h55;
      finish_op(0, 3, 3, 1'b1, 16'h30, 1'b0, 1'b0, "ignored start 10+20");

      // Start during the done cycle: no idle gap
      launch(0, 16'h01, 16'h01, 1'b0);
      check("back-to-back busy", {31'h0, b8}, 32'h1);
      finish_op(0, 0, 0, 1'b1, 16'h02, 1'b0, 1'b0, "back-to-back 01+01");
      @(negedge clk);

      // Reset mid-operation abandons it without a done pulse
      do_op(0, 16'h3C, 16'h0F, 1'b0, 16'h4B, 1'b0, 1'b0, "pre-reset 3C+0F");
      launch(0, 16'h11, 16'h22, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async reset outputs", {b8, d8, c8, o8, sum8}, 32'h0);
      repeat (2) @(negedge clk);
      check("no done in reset", {31'h0, d8}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(0, 16'h01, 16'h02, 1'b0, 16'h03, 1'b0, 1'b0, "post-reset 01+02");

      for (int k = 0; k < 2; k++) begin
         for (int n = 0; n < 1000; n++) begin
            launch(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            finish_op(k, 0, 0, 1'b0, 16'h0, 1'b0, 1'b0, $sformatf("random w%0d", wof(k)));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
         end
         @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
